fpu_issue_ctrl: RTL and testbench

FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

---
 rtl/fpu_issue_ctrl_pkg.sv | 44 ++++
 rtl/fpu_issue_ctrl_lat_lut.sv | 23 ++
 rtl/fpu_issue_ctrl.sv | 95 +++++++++
 tb/tb_fpu_issue_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared FPU definitions: opcode encoding, default execution latencies and
// issue-controller state encoding.
package fpu_issue_ctrl_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 5;
   localparam int unsigned TAG_W  = 5;
   localparam int unsigned CNT_W  = 4;

   localparam int unsigned DEF_LAT_ADD = 2;
   localparam int unsigned DEF_LAT_MUL = 2;
   localparam int unsigned DEF_LAT_DIV = 4;

   // Defined opcodes occupy 0..15 contiguously; 16..31 are undefined.
   typedef enum logic [OP_W-1:0] {
      OP_FADD     = 5'd0,
      OP_FSUB     = 5'd1,
      OP_FMUL     = 5'd2,
      OP_FDIV     = 5'd3,
      OP_FSQRT    = 5'd4,
      OP_FSGNJ    = 5'd5,
      OP_FSGNJN   = 5'd6,
      OP_FSGNJX   = 5'd7,
      OP_FCVT_W_S = 5'd8,
      OP_FCVT_S_W = 5'd9,
      OP_FMV_X_W  = 5'd10,
      OP_FMV_W_X  = 5'd11,
      OP_FEQ      = 5'd12,
      OP_FLE      = 5'd13,
      OP_FLW      = 5'd14,
      OP_FSW      = 5'd15
   } fpu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } issue_state_t;

   function automatic logic op_defined(input logic [OP_W-1:0] op);
      return (op <= OP_FSW);
   endfunction

endpackage

// File: rtl/fpu_issue_ctrl_lat_lut.sv
// Combinational opcode -> execution latency lookup.
module fpu_lat_lut
   import fpu_issue_ctrl_pkg::*;
#(
   parameter int unsigned LAT_ADD = DEF_LAT_ADD,
   parameter int unsigned LAT_MUL = DEF_LAT_MUL,
   parameter int unsigned LAT_DIV = DEF_LAT_DIV
) (
   input  logic [OP_W-1:0]  op,
   output logic [CNT_W-1:0] lat
);

   always_comb begin
      lat = CNT_W'(1);
      case (op)
         OP_FADD, OP_FSUB:  lat = CNT_W'(LAT_ADD);
         OP_FMUL:           lat = CNT_W'(LAT_MUL);
         OP_FDIV, OP_FSQRT: lat = CNT_W'(LAT_DIV);
         default:           lat = CNT_W'(1);
      endcase
   end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding FPU issue controller: accepts one op, holds the datapath
// inputs for its latency, then presents the captured result until consumed.
module fpu_issue_ctrl
   import fpu_issue_ctrl_pkg::*;
#(
   parameter int unsigned LAT_ADD = DEF_LAT_ADD,
   parameter int unsigned LAT_MUL = DEF_LAT_MUL,
   parameter int unsigned LAT_DIV = DEF_LAT_DIV
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [TAG_W-1:0]  req_rd,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic [OP_W-1:0]   dp_op,
   output logic [DATA_W-1:0] dp_a,
   output logic [DATA_W-1:0] dp_b,
   input  logic [DATA_W-1:0] dp_result,
   input  logic              dp_exc,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [TAG_W-1:0]  resp_rd,
   output logic              resp_exc,
   input  logic              flush,
   output logic              busy
);

   issue_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] req_lat;
   logic             req_fire;
   logic             resp_fire;

   fpu_lat_lut #(
      .LAT_ADD (LAT_ADD),
      .LAT_MUL (LAT_MUL),
      .LAT_DIV (LAT_DIV)
   ) u_lat (
      .op  (req_op),
      .lat (req_lat)
   );

   assign resp_valid = (state == ST_DONE);
   assign busy       = (state != ST_IDLE);
   // Accepting in DONE is only allowed alongside the response transfer.
   assign req_ready  = !rst && !flush &&
                       ((state == ST_IDLE) || ((state == ST_DONE) && resp_ready));
   assign req_fire   = req_valid && req_ready;
   assign resp_fire  = resp_valid && resp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         dp_op     <= '0;
         dp_a      <= '0;
         dp_b      <= '0;
         resp_data <= '0;
         resp_rd   <= '0;
         resp_exc  <= 1'b0;
      end else if (flush) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: ;
            ST_EXEC: begin
               if (cnt == '0) begin
                  // Undefined opcodes report a zero result with the exception flag.
                  resp_data <= op_defined(dp_op) ? dp_result : '0;
                  resp_exc  <= op_defined(dp_op) ? dp_exc : 1'b1;
                  state     <= ST_DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_DONE: if (resp_fire) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         if (req_fire) begin
            state   <= ST_EXEC;
            cnt     <= req_lat - CNT_W'(1);
            dp_op   <= req_op;
            dp_a    <= req_a;
            dp_b    <= req_b;
            resp_rd <= req_rd;
         end
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios plus random traffic, every cycle
// compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;
   import fpu_issue_ctrl_pkg::*;

   localparam int TB_LAT_ADD = 2;
   localparam int TB_LAT_MUL = 2;
   localparam int TB_LAT_DIV = 4;

   logic        clk = 1'b0;
   logic        rst, req_valid, req_ready, resp_valid, resp_ready, resp_exc;
   logic        flush, busy, dp_exc, dp_mode;
   logic [4:0]  req_op, req_rd, dp_op, resp_rd;
   logic [31:0] req_a, req_b, dp_a, dp_b, dp_result, resp_data;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: one outstanding transaction and the cycles left until it responds.
   bit          m_have;
   int          m_wait;
   logic [4:0]  m_op, m_rd;
   logic [31:0] m_a, m_b;

   logic        s_req_ready, s_resp_valid, s_busy, s_resp_exc;
   logic [4:0]  s_dp_op, s_resp_rd;
   logic [31:0] s_dp_a, s_dp_b, s_resp_data;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(
      .LAT_ADD (TB_LAT_ADD),
      .LAT_MUL (TB_LAT_MUL),
      .LAT_DIV (TB_LAT_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_rd     (req_rd),
      .req_a      (req_a),
      .req_b      (req_b),
      .dp_op      (dp_op),
      .dp_a       (dp_a),
      .dp_b       (dp_b),
      .dp_result  (dp_result),
      .dp_exc     (dp_exc),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_rd    (resp_rd),
      .resp_exc   (resp_exc),
      .flush      (flush),
      .busy       (busy)
   );

   function automatic logic [31:0] dp_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      return (a ^ {b[15:0], b[31:16]}) + ({27'd0, op} * 32'h0101_0101);
   endfunction

   function automatic logic dp_exc_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      return a[31] ^ b[0] ^ op[1];
   endfunction

   // Stand-in for the external combinational datapath.
   always_comb begin
      dp_result = dp_mode ? 32'h4040_0000 : dp_fn(dp_op, dp_a, dp_b);
      dp_exc    = dp_mode ? 1'b0 : dp_exc_fn(dp_op, dp_a, dp_b);
   end

   function automatic bit is_known(input logic [4:0] op);
      return op inside {OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FSQRT, OP_FSGNJ, OP_FSGNJN,
                        OP_FSGNJX, OP_FCVT_W_S, OP_FCVT_S_W, OP_FMV_X_W, OP_FMV_W_X,
                        OP_FEQ, OP_FLE, OP_FLW, OP_FSW};
   endfunction

   function automatic int ref_lat(input logic [4:0] op);
      if (op == OP_FADD || op == OP_FSUB) return TB_LAT_ADD;
      if (op == OP_FMUL) return TB_LAT_MUL;
      if (op == OP_FDIV || op == OP_FSQRT) return TB_LAT_DIV;
      return 1;
   endfunction

   function automatic logic [31:0] ref_data(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!is_known(op)) return 32'd0;
      return dp_mode ? 32'h4040_0000 : dp_fn(op, a, b);
   endfunction

   function automatic logic ref_exc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!is_known(op)) return 1'b1;
      return dp_mode ? 1'b0 : dp_exc_fn(op, a, b);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample and compare mid-cycle, then advance the model at the edge.
   task automatic step();
      bit e_rv, e_rr, rsp_fire, rq_fire;
      @(negedge clk);
      s_req_ready  = req_ready;
      s_resp_valid = resp_valid;
      s_busy       = busy;
      s_resp_exc   = resp_exc;
      s_dp_op      = dp_op;
      s_dp_a       = dp_a;
      s_dp_b       = dp_b;
      s_resp_data  = resp_data;
      s_resp_rd    = resp_rd;
      e_rv = m_have && (m_wait == 0);
      e_rr = !rst && !flush && (!m_have || (e_rv && resp_ready));
      check("resp_valid", s_resp_valid, e_rv);
      check("busy", s_busy, m_have);
      check("req_ready", s_req_ready, e_rr);
      if (m_have) begin
         check("dp_op", s_dp_op, m_op);
         check("dp_a", s_dp_a, m_a);
         check("dp_b", s_dp_b, m_b);
      end
      if (e_rv) begin
         check("resp_data", s_resp_data, ref_data(m_op, m_a, m_b));
         check("resp_exc", s_resp_exc, ref_exc(m_op, m_a, m_b));
         check("resp_rd", s_resp_rd, m_rd);
      end
      rsp_fire = e_rv && resp_ready;
      rq_fire  = req_valid && e_rr;
      @(posedge clk);
      if (rst || flush) begin
         m_have = 0;
      end else begin
         if (rsp_fire) m_have = 0;
         else if (m_have && m_wait > 0) m_wait--;
         if (rq_fire) begin
            m_have = 1;
            m_wait = ref_lat(req_op);
            m_op   = req_op;
            m_a    = req_a;
            m_b    = req_b;
            m_rd   = req_rd;
         end
      end
      #1;
   endtask

   task automatic check_reset_vals(input string ctx);
      check({ctx, "_resp_valid"}, s_resp_valid, 32'd0);
      check({ctx, "_busy"}, s_busy, 32'd0);
      check({ctx, "_dp_op"}, s_dp_op, 32'd0);
      check({ctx, "_dp_a"}, s_dp_a, 32'd0);
      check({ctx, "_dp_b"}, s_dp_b, 32'd0);
      check({ctx, "_resp_data"}, s_resp_data, 32'd0);
      check({ctx, "_resp_rd"}, s_resp_rd, 32'd0);
      check({ctx, "_resp_exc"}, s_resp_exc, 32'd0);
   endtask

   task automatic drive_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_rd    = rd;
   endtask

   initial begin
      logic [31:0] held_data;
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rd = '0; req_a = '0; req_b = '0;
      resp_ready = 1'b0; flush = 1'b0; dp_mode = 1'b0;
      m_have = 0; m_wait = 0; m_op = '0; m_rd = '0; m_a = '0; m_b = '0;
      @(posedge clk); #1;

      // Reset behaviour
      step();
      check("rst_req_ready_low", s_req_ready, 32'd0);
      step();
      rst = 1'b0;
      step();
      check_reset_vals("post_rst");
      check("post_rst_req_ready", s_req_ready, 32'd1);

      // fadd 1.0 + 2.0 with an always-ready consumer
      dp_mode = 1'b1; resp_ready = 1'b1;
      drive_req(OP_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd7);
      step();
      check("fadd_accept", s_req_ready, 32'd1);
      req_valid = 1'b0;
      step(); check("fadd_t1_rv", s_resp_valid, 32'd0);
      step(); check("fadd_t2_rv", s_resp_valid, 32'd0);
      step();
      check("fadd_t3_rv", s_resp_valid, 32'd1);
      check("fadd_t3_data", s_resp_data, 32'h4040_0000);
      check("fadd_t3_rd", s_resp_rd, 32'd7);
      step(); check("fadd_t4_rv", s_resp_valid, 32'd0);
      dp_mode = 1'b0;

      // fdiv with a stalled consumer
      resp_ready = 1'b0;
      drive_req(OP_FDIV, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
      step();
      req_valid = 1'b0;
      repeat (TB_LAT_DIV) step();
      held_data = dp_fn(OP_FDIV, 32'h1234_5678, 32'h9ABC_DEF0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("fdiv_stall_rv", s_resp_valid, 32'd1);
         check("fdiv_stall_data", s_resp_data, held_data);
         check("fdiv_stall_rr", s_req_ready, 32'd0);
      end
      resp_ready = 1'b1;
      step();
      check("fdiv_release_rr", s_req_ready, 32'd1);
      step();
      check("fdiv_after_rv", s_resp_valid, 32'd0);

      // fsgnj then fmul with req_valid held: zero-bubble reissue
      drive_req(OP_FSGNJ, 32'hC000_0000, 32'h3F00_0000, 5'd1);
      step();
      drive_req(OP_FMUL, 32'h4100_0000, 32'h4200_0000, 5'd2);
      step(); check("b2b_exec_rr", s_req_ready, 32'd0);
      step();
      check("b2b_resp1_rv", s_resp_valid, 32'd1);
      check("b2b_accept2", s_req_ready, 32'd1);
      check("b2b_resp1_rd", s_resp_rd, 32'd1);
      req_valid = 1'b0;
      step(); check("b2b_p1_rv", s_resp_valid, 32'd0);
      step(); check("b2b_p2_rv", s_resp_valid, 32'd0);
      step();
      check("b2b_p3_rv", s_resp_valid, 32'd1);
      check("b2b_p3_rd", s_resp_rd, 32'd2);
      step();

      // flush in the second fdiv EXEC cycle, with a competing request
      drive_req(OP_FDIV, 32'h0000_0011, 32'h0000_0022, 5'd9);
      step();
      req_valid = 1'b0;
      step();
      flush = 1'b1;
      drive_req(OP_FADD, 32'h5, 32'h6, 5'd10);
      step(); check("flush_rr", s_req_ready, 32'd0);
      flush = 1'b0; req_valid = 1'b0;
      step();
      check("flush_busy", s_busy, 32'd0);
      check("flush_rr_after", s_req_ready, 32'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         check("flush_no_resp", s_resp_valid, 32'd0);
      end

      // undefined opcode
      drive_req(5'h1F, 32'hFFFF_FFFF, 32'h1, 5'd4);
      step();
      req_valid = 1'b0;
      step(); check("undef_t1_rv", s_resp_valid, 32'd0);
      step();
      check("undef_t2_rv", s_resp_valid, 32'd1);
      check("undef_data", s_resp_data, 32'd0);
      check("undef_exc", s_resp_exc, 32'd1);
      step();

      // reset while a response is pending
      resp_ready = 1'b0;
      drive_req(OP_FADD, 32'hAAAA_5555, 32'h1357_9BDF, 5'd12);
      step();
      req_valid = 1'b0;
      repeat (TB_LAT_ADD) step();
      step(); check("rstdone_rv", s_resp_valid, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check_reset_vals("rstdone");
      check("rstdone_rr", s_req_ready, 32'd1);
      resp_ready = 1'b1;
      drive_req(OP_FMUL, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd13);
      step(); check("rstdone_accept", s_req_ready, 32'd1);
      req_valid = 1'b0;
      repeat (TB_LAT_MUL) step();
      step(); check("rstdone_new_rv", s_resp_valid, 32'd1);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         req_valid  = ($urandom_range(0, 9) < 6);
         req_op     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
         req_a      = $urandom;
         req_b      = $urandom;
         req_rd     = 5'($urandom_range(0, 31));
         resp_ready = $urandom_range(0, 1) == 1;
         flush      = ($urandom_range(0, 39) == 0);
         rst        = ($urandom_range(0, 59) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
